// File: rtl/dispenser_cafea_if.sv
// dispenser_cafea_if: selection inputs and dispenser outputs between the coin FSM and the dispenser
interface dispenser_cafea_if;
  logic [1:0] cafea;
  logic [1:0] rest;
  logic       busy;
  logic       pompa;
  logic       moneda;
  logic       gata;
  logic [7:0] cafele_servite;
  modport master (output cafea, rest, input busy, pompa, moneda, gata, cafele_servite);
  modport slave  (input cafea, rest, output busy, pompa, moneda, gata, cafele_servite);
endinterface

// File: rtl/dispenser_cafea.sv
// dispenser_cafea: brews up to 3 coffees with pump/pause timing, then returns change coins
module dispenser_cafea #(
  parameter int unsigned BREW_CYCLES  = 8,
  parameter int unsigned PAUSE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  dispenser_cafea_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, BREW, PAUSE, CHANGE, DONE} state_t;
  localparam logic [7:0] BREW_LD  = 8'(BREW_CYCLES - 1);
  localparam logic [7:0] PAUSE_LD = 8'(PAUSE_CYCLES - 1);
  state_t     state_q, state_d;
  logic [1:0] cup_q, cup_d, coin_q, coin_d;
  logic [7:0] timer_q, timer_d, served_q, served_d;
  logic       busy_q, busy_d, pompa_q, pompa_d, moneda_q, moneda_d, gata_q, gata_d;
  always_comb begin
    state_d  = state_q;
    cup_d    = cup_q;
    coin_d   = coin_q;
    timer_d  = timer_q;
    served_d = served_q;
    case (state_q)
      IDLE: if (bus.cafea != 2'd0 || bus.rest != 2'd0) begin
        cup_d   = bus.cafea;
        coin_d  = bus.rest;
        timer_d = bus.cafea != 2'd0 ? BREW_LD : 8'd0;
        state_d = bus.cafea != 2'd0 ? BREW : CHANGE;
      end
      BREW: if (timer_q != 8'd0) timer_d = timer_q - 8'd1;
      else begin
        cup_d    = cup_q - 2'd1;
        served_d = served_q + 8'd1;
        timer_d  = cup_q != 2'd1 ? PAUSE_LD : 8'd0;
        state_d  = cup_q != 2'd1 ? PAUSE : coin_q != 2'd0 ? CHANGE : DONE;
      end
      PAUSE: begin
        timer_d = timer_q != 8'd0 ? timer_q - 8'd1 : BREW_LD;
        state_d = timer_q != 8'd0 ? PAUSE : BREW;
      end
      // timer bit 0 doubles as the coin phase: 0 = pulse high, 1 = gap where the coin is retired
      CHANGE: if (timer_q == 8'd0) timer_d = 8'd1;
      else begin
        timer_d = 8'd0;
        coin_d  = coin_q - 2'd1;
        state_d = coin_q == 2'd1 ? DONE : CHANGE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d   = state_d != IDLE;
    pompa_d  = state_d == BREW;
    moneda_d = state_d == CHANGE && timer_d == 8'd0;
    gata_d   = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cup_q    <= '0;
      coin_q   <= '0;
      timer_q  <= '0;
      served_q <= '0;
      busy_q   <= 1'b0;
      pompa_q  <= 1'b0;
      moneda_q <= 1'b0;
      gata_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cup_q    <= cup_d;
      coin_q   <= coin_d;
      timer_q  <= timer_d;
      served_q <= served_d;
      busy_q   <= busy_d;
      pompa_q  <= pompa_d;
      moneda_q <= moneda_d;
      gata_q   <= gata_d;
    end
  end
  assign bus.busy           = busy_q;
  assign bus.pompa          = pompa_q;
  assign bus.moneda         = moneda_q;
  assign bus.gata           = gata_q;
  assign bus.cafele_servite = served_q;
endmodule

// File: tb/tb_dispenser_cafea.sv
// tb_dispenser_cafea: directed vectors with hand-computed cycle expectations
module tb_dispenser_cafea;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  dispenser_cafea_if bus ();
  dispenser_cafea #(.BREW_CYCLES(8), .PAUSE_CYCLES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [1:0] c, input logic [1:0] r);
    bus.cafea = c;
    bus.rest  = r;
    tick();
    bus.cafea = 2'd0;
    bus.rest  = 2'd0;
  endtask
  task automatic outs(input string tag, input logic p, input logic m, input logic g, input logic b);
    check({tag, " pompa"}, 32'(bus.pompa), 32'(p));
    check({tag, " moneda"}, 32'(bus.moneda), 32'(m));
    check({tag, " gata"}, 32'(bus.gata), 32'(g));
    check({tag, " busy"}, 32'(bus.busy), 32'(b));
  endtask
  task automatic coffee1;
    int k;
    req(2'd1, 2'd0);
    check("c1 pompa", 32'(bus.pompa), 32'd1);
    k = 0;
    while (bus.busy && k < 30) begin
      tick();
      k++;
    end
    check("c1 drain", 32'(k), 32'd9);
  endtask
  initial begin
    bus.cafea = 2'd0;
    bus.rest  = 2'd0;
    tick();
    tick();
    outs("reset", 0, 0, 0, 0);
    check("reset served", 32'(bus.cafele_servite), 32'd0);
    reset = 1'b0;
    tick();
    req(2'd1, 2'd0);
    for (int c = 1; c <= 10; c++) begin
      outs($sformatf("one c%0d", c), c <= 8, 0, c == 9, c <= 9);
      if (c < 10) tick();
    end
    check("one served", 32'(bus.cafele_servite), 32'd1);
    req(2'd2, 2'd0);
    for (int c = 1; c <= 20; c++) begin
      outs($sformatf("two c%0d", c), c <= 8 || (c >= 11 && c <= 18), 0, c == 19, c <= 19);
      if (c < 20) tick();
    end
    check("two served", 32'(bus.cafele_servite), 32'd3);
    req(2'd1, 2'd2);
    for (int c = 1; c <= 14; c++) begin
      outs($sformatf("chg c%0d", c), c <= 8, c == 9 || c == 11, c == 13, c <= 13);
      if (c < 14) tick();
    end
    check("chg served", 32'(bus.cafele_servite), 32'd4);
    req(2'd0, 2'd1);
    for (int c = 1; c <= 5; c++) begin
      outs($sformatf("only c%0d", c), 0, c == 1, c == 3, c <= 3);
      if (c == 2) bus.cafea = 2'd1;
      if (c < 5) tick();
      if (c == 2) bus.cafea = 2'd0;
    end
    check("only served", 32'(bus.cafele_servite), 32'd4);
    req(2'd1, 2'd0);
    tick();
    tick();
    tick();
    outs("abort c4", 1, 0, 0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    outs("abort c5", 0, 0, 0, 0);
    check("abort served", 32'(bus.cafele_servite), 32'd0);
    reset = 1'b1;
    bus.cafea = 2'd1;
    tick();
    reset = 1'b0;
    bus.cafea = 2'd0;
    outs("race c1", 0, 0, 0, 0);
    tick();
    outs("race c2", 0, 0, 0, 0);
    coffee1();
    check("post served", 32'(bus.cafele_servite), 32'd1);
    for (int i = 0; i < 254; i++) coffee1();
    check("pre wrap", 32'(bus.cafele_servite), 32'd255);
    coffee1();
    check("wrap", 32'(bus.cafele_servite), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
